// File: rtl/vlsu_seg_splitter.sv
// Splits one unit-stride vector memory request into AXI-legal segments that never cross a page and
// never exceed MAX_BEATS beats. Emits one meta record per segment on a valid/ready interface.
module vlsu_seg_splitter #(
  parameter int unsigned ALEN       = 32,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned BUS_BYTES  = 16,
  parameter int unsigned MAX_BEATS  = 64,
  parameter int unsigned PAGE_BYTES = 4096
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [ALEN-1:0]              req_addr_i,
  input  logic [LEN_W-1:0]             req_len_m1_i,
  input  logic                         req_is_load_i,
  output logic                         meta_valid_o,
  input  logic                         meta_ready_i,
  output logic [ALEN-1:0]              seg_base_addr_o,
  output logic [7:0]                   seg_txn_num_o,
  output logic [$clog2(BUS_BYTES)-1:0] seg_lt_n_o,
  output logic                         seg_is_load_o,
  output logic                         seg_is_final_o,
  output logic                         busy_o
);

  localparam int unsigned OffW  = $clog2(BUS_BYTES);
  localparam int unsigned PageW = $clog2(PAGE_BYTES);
  localparam int unsigned RemW  = LEN_W + 1;
  localparam int unsigned CW    = 32;

  typedef enum logic {StIdle, StSplit} state_e;

  state_e            state_q, state_d;
  logic [ALEN-1:0]   cur_addr_q, cur_addr_d;
  logic [RemW-1:0]   rem_bytes_q, rem_bytes_d;
  logic              is_load_q, is_load_d;

  logic [CW-1:0]     rem_beats, page_beats, seg_beats, seg_bytes;
  logic              is_final;

  always_comb begin
    rem_beats  = (CW'(rem_bytes_q) + CW'(BUS_BYTES - 1)) >> OffW;
    page_beats = (CW'(PAGE_BYTES) - CW'(cur_addr_q[PageW-1:0])) >> OffW;
    seg_beats  = rem_beats;
    if (page_beats < seg_beats) seg_beats = page_beats;
    if (CW'(MAX_BEATS) < seg_beats) seg_beats = CW'(MAX_BEATS);
    seg_bytes  = seg_beats << OffW;
    is_final   = (seg_beats == rem_beats);
  end

  assign req_ready_o     = (state_q == StIdle);
  assign meta_valid_o    = (state_q == StSplit);
  assign busy_o          = (state_q == StSplit);
  assign seg_base_addr_o = cur_addr_q;
  assign seg_txn_num_o   = 8'(seg_beats - CW'(1));
  // (rem_bytes - 1) mod BUS_BYTES only depends on the low offset bits.
  assign seg_lt_n_o      = is_final ? OffW'(rem_bytes_q[OffW-1:0] - OffW'(1)) : '1;
  assign seg_is_load_o   = is_load_q;
  assign seg_is_final_o  = is_final;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    rem_bytes_d = rem_bytes_q;
    is_load_d   = is_load_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          cur_addr_d  = req_addr_i & ~ALEN'(BUS_BYTES - 1);
          rem_bytes_d = RemW'(req_len_m1_i) + RemW'(1);
          is_load_d   = req_is_load_i;
          state_d     = StSplit;
        end
      end
      StSplit: begin
        if (meta_ready_i) begin
          if (is_final) begin
            state_d = StIdle;
          end else begin
            cur_addr_d  = cur_addr_q + ALEN'(seg_bytes);
            rem_bytes_d = rem_bytes_q - RemW'(seg_bytes);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      rem_bytes_q <= '0;
      is_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      rem_bytes_q <= rem_bytes_d;
      is_load_q   <= is_load_d;
    end
  end

endmodule

// File: tb/tb_vlsu_seg_splitter.sv
// Table-driven bench for vlsu_seg_splitter: each vector is a request with its expected segment
// records; inputs are driven and outputs sampled on the falling clock edge.
module tb_vlsu_seg_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_load;
  logic [31:0] req_addr;
  logic [15:0] req_len_m1;
  logic        meta_valid, meta_ready;
  logic [31:0] seg_base_addr;
  logic [7:0]  seg_txn_num;
  logic [3:0]  seg_lt_n;
  logic        seg_is_load, seg_is_final, busy;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  vlsu_seg_splitter dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_addr_i      (req_addr),
    .req_len_m1_i    (req_len_m1),
    .req_is_load_i   (req_is_load),
    .meta_valid_o    (meta_valid),
    .meta_ready_i    (meta_ready),
    .seg_base_addr_o (seg_base_addr),
    .seg_txn_num_o   (seg_txn_num),
    .seg_lt_n_o      (seg_lt_n),
    .seg_is_load_o   (seg_is_load),
    .seg_is_final_o  (seg_is_final),
    .busy_o          (busy)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  txn;
    logic [3:0]  lt;
    logic        fin;
  } rec_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [15:0] len_m1;
    logic        is_load;
    int          stall;
    int          nrec;
    rec_t        r0;
    rec_t        r1;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_rec(input string name, input rec_t r, input logic ld);
    check({name, " valid"}, 64'(meta_valid), 64'(1'b1));
    check({name, " addr"}, 64'(seg_base_addr), 64'(r.addr));
    check({name, " txn"}, 64'(seg_txn_num), 64'(r.txn));
    check({name, " lt_n"}, 64'(seg_lt_n), 64'(r.lt));
    check({name, " final"}, 64'(seg_is_final), 64'(r.fin));
    check({name, " is_load"}, 64'(seg_is_load), 64'(ld));
    check({name, " busy/ready"}, 64'({busy, req_ready}), 64'(2'b10));
  endtask

  // Accept the request at the next rising edge; left in the first SPLIT cycle.
  task automatic issue(input vec_t v);
    check({v.name, " idle ready"}, 64'(req_ready), 64'(1'b1));
    req_valid   = 1'b1;
    req_addr    = v.addr;
    req_len_m1  = v.len_m1;
    req_is_load = v.is_load;
    @(negedge clk);
    req_valid   = 1'b0;
    req_addr    = 32'hDEAD_BEE0;
    req_len_m1  = 16'hFFFF;
    req_is_load = ~v.is_load;
  endtask

  task automatic run_vec(input vec_t v);
    rec_t r;
    issue(v);
    for (int i = 0; i < v.nrec; i++) begin
      r = (i == 0) ? v.r0 : v.r1;
      for (int s = 0; s < v.stall; s++) begin
        meta_ready = 1'b0;
        check_rec($sformatf("%s rec%0d stall%0d", v.name, i, s), r, v.is_load);
        @(negedge clk);
      end
      meta_ready = 1'b1;
      check_rec($sformatf("%s rec%0d", v.name, i), r, v.is_load);
      @(negedge clk);
    end
    meta_ready = 1'b0;
    check({v.name, " done valid/busy/ready"}, 64'({meta_valid, busy, req_ready}), 64'(3'b001));
  endtask

  initial begin
    vecs[0] = '{"single", 32'h100, 16'd47, 1'b1, 0, 1,
                '{32'h100, 8'd2, 4'd15, 1'b1}, '0};
    vecs[1] = '{"page", 32'hFE0, 16'd99, 1'b0, 0, 2,
                '{32'hFE0, 8'd1, 4'd15, 1'b0}, '{32'h1000, 8'd4, 4'd3, 1'b1}};
    vecs[2] = '{"maxbeats", 32'h0, 16'd2047, 1'b1, 0, 2,
                '{32'h0, 8'd63, 4'd15, 1'b0}, '{32'h400, 8'd63, 4'd15, 1'b1}};
    vecs[3] = '{"page_bp", 32'hFE0, 16'd99, 1'b1, 3, 2,
                '{32'hFE0, 8'd1, 4'd15, 1'b0}, '{32'h1000, 8'd4, 4'd3, 1'b1}};
    vecs[4] = '{"byte_ld", 32'h20, 16'd0, 1'b1, 0, 1,
                '{32'h20, 8'd0, 4'd0, 1'b1}, '0};
    vecs[5] = '{"byte_st", 32'h20, 16'd0, 1'b0, 0, 1,
                '{32'h20, 8'd0, 4'd0, 1'b1}, '0};
    vecs[6] = '{"one_beat_page", 32'hFF0, 16'd31, 1'b0, 1, 2,
                '{32'hFF0, 8'd0, 4'd15, 1'b0}, '{32'h1000, 8'd0, 4'd15, 1'b1}};

    rst         = 1'b1;
    req_valid   = 1'b0;
    req_addr    = '0;
    req_len_m1  = '0;
    req_is_load = 1'b0;
    meta_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset valid/busy/ready", 64'({meta_valid, busy, req_ready}), 64'(3'b001));
    check("reset addr", 64'(seg_base_addr), 64'(0));
    check("reset is_load", 64'(seg_is_load), 64'(0));

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset while the first MAX_BEATS record is stalled.
    issue(vecs[2]);
    check_rec("rst_mid rec0", vecs[2].r0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid valid/busy/ready", 64'({meta_valid, busy, req_ready}), 64'(3'b001));
    @(negedge clk);
    check("rst_mid stays idle", 64'({meta_valid, busy, req_ready}), 64'(3'b001));
    run_vec(vecs[1]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
